universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised WIDTH-bit clocked storage register with complementary outputs (q / q_n).
//  Successor to the single-bit gated D latch: edge-triggered, gated by enable, with hold,
//  parallel load, single-step shift left/right and a multi-cycle shift-by-N engine (FSM).
//  Used as a general data/shift register in datapath and serialiser blocks.
// PARAMETERS
//  WIDTH      8      data width in bits (>= 2)
//  CNT_W      4      width of shift-amount input/counter
//  RESET_VAL  0      value loaded into q on reset (WIDTH bits)
// PORTS
//  clock     in   1        rising-edge clock; sole clock
//  reset     in   1        synchronous, active-high reset
//  enable    in   1        clock-enable; 0 = freeze everything (no state change)
//  mode      in   2        00 hold, 01 load d, 10 shift left, 11 shift right
//  d         in   WIDTH    parallel load data
//  ser_in_l  in   1        bit entering MSB on right shift
//  ser_in_r  in   1        bit entering LSB on left shift
//  start     in   1        request multi-cycle shift of `amount` in direction of mode
//  amount    in   CNT_W    number of positions for start
//  q         out  WIDTH    register value
//  q_n       out  WIDTH    bitwise complement of q, always
//  busy      out  1        1 while FSM in SHIFT
//  done      out  1        1-cycle pulse at completion of a start request
// BEHAVIOUR
//  - Reset (sync, priority over all): q=RESET_VAL, q_n=~RESET_VAL, busy=0, done=0, FSM=IDLE,
//    remaining count=0. Reset mid-SHIFT aborts; no done pulse is produced.
//  - All outputs registered; q_n == ~q at every cycle; done defaults 0 each cycle.
//  - FSM states: IDLE, SHIFT. busy = (state==SHIFT).
//  - IDLE, enable=1, start=0: mode 00 q holds; 01 q<=d (1-cycle latency);
//    10 q<={q[WIDTH-2:0],ser_in_r}; 11 q<={ser_in_l,q[WIDTH-1:1]}.
//  - IDLE, enable=1, start=1, mode in {10,11}: direction latched from mode[0];
//      amount!=0 -> remaining<=amount, FSM->SHIFT, q unchanged on this edge;
//      amount==0 -> done=1 next cycle, q unchanged, stays IDLE.
//    start with mode 00/01 is ignored; mode executes as normal.
//  - SHIFT, enable=1: one shift per edge in latched direction, remaining-=1; on the edge
//    where remaining goes 1->0: FSM->IDLE, busy=0, done=1 (same cycle final q visible).
//    A start of amount N gives busy high exactly N enabled cycles.
//  - SHIFT: mode, d, start, amount ignored; serial inputs sampled each shift edge.
//  - enable=0 (any state): q, FSM, remaining frozen; start not captured; done=0.
//  - amount > WIDTH allowed: register fully flushed with serial input (or rotated).
// CONFIGURATION
//  SHIFT_ROTATE_EN defined: all shifts (single and multi) rotate; left moves q[WIDTH-1]
//    into bit 0, right moves q[0] into bit WIDTH-1; ser_in_l/ser_in_r ignored.
//  Not defined: shifts use ser_in_l / ser_in_r as above; no rotate path synthesised.
// TESTING (WIDTH=8, CNT_W=4, RESET_VAL=0, macro undefined unless noted)
//  1. reset=1 one edge -> q=0x00, q_n=0xFF, busy=0, done=0.
//  2. enable=1 mode=01 d=0xA5 -> next edge q=0xA5 q_n=0x5A; then enable=0 d=0x3C -> q stays 0xA5.
//  3. q=0xA5, mode=10 ser_in_r=1 one edge -> q=0x4B; mode=00 -> q holds 0x4B.
//  4. q=0xA5, start=1 mode=11 amount=3 ser_in_l=0 -> busy 3 cycles, q=0x14, done one cycle
//     at busy fall; repeat with enable=0 for 1 mid-shift cycle -> busy 4 cycles, same q.
//  5. start amount=5 then reset=1 after 2 shifts -> q=0x00, busy=0, done never asserted.
//  6. start amount=0 -> done one cycle, busy stays 0, q unchanged;
//     SHIFT_ROTATE_EN defined: q=0x81 mode=10 one edge -> q=0x03.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit clock-enabled register with complementary outputs.
// Supports hold, parallel load, single-step shift left/right and a multi-cycle
// shift-by-N engine (IDLE/SHIFT FSM) that reports completion with a done pulse.
// Build option: define SHIFT_ROTATE_EN to make every shift a rotate; the serial
// inputs are then unused.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_RIGHT = 2'b11;

  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] remainingReg, remainingNext;
  logic             dirRightReg, dirRightNext;
  logic [WIDTH-1:0] qReg, qNext;
  logic [WIDTH-1:0] qNReg;
  logic             doneReg, doneNext;

  // Candidate next values for a one-position shift in each direction.
  logic [WIDTH-1:0] leftVec;
  logic [WIDTH-1:0] rightVec;
  logic             leftFill;
  logic             rightFill;

`ifdef SHIFT_ROTATE_EN
  // Rotate: the bit falling off one end re-enters at the other.
  assign leftFill  = qReg[WIDTH-1];
  assign rightFill = qReg[0];
`else
  // Plain shift: the vacated end is filled from the matching serial input.
  assign leftFill  = ser_in_r;
  assign rightFill = ser_in_l;
`endif

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : gen_shift_bits
      assign leftVec[gi]    = qReg[gi-1];
      assign rightVec[gi-1] = qReg[gi];
    end
  endgenerate

  assign leftVec[0]        = leftFill;
  assign rightVec[WIDTH-1] = rightFill;

  // Next-state, next-data and done-pulse decode; enable low freezes everything.
  always_comb begin
    stateNext     = stateReg;
    remainingNext = remainingReg;
    dirRightNext  = dirRightReg;
    qNext         = qReg;
    doneNext      = 1'b0;
    if (enable) begin
      case (stateReg)
        IDLE: begin
          if (start && mode[1]) begin
            // Multi-cycle request: latch direction, q untouched on this edge.
            dirRightNext = mode[0];
            if (amount != '0) begin
              remainingNext = amount;
              stateNext     = SHIFT;
            end else begin
              doneNext = 1'b1;
            end
          end else begin
            case (mode)
              MODE_HOLD:  qNext = qReg;
              MODE_LOAD:  qNext = d;
              MODE_LEFT:  qNext = leftVec;
              MODE_RIGHT: qNext = rightVec;
              default:    qNext = qReg;
            endcase
          end
        end
        SHIFT: begin
          qNext         = dirRightReg ? rightVec : leftVec;
          remainingNext = remainingReg - 1'b1;
          if (remainingReg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any shift in progress without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg     <= IDLE;
      remainingReg <= '0;
      dirRightReg  <= 1'b0;
      qReg         <= RESET_VAL;
      qNReg        <= ~RESET_VAL;
      doneReg      <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      remainingReg <= remainingNext;
      dirRightReg  <= dirRightNext;
      qReg         <= qNext;
      qNReg        <= ~qNext;
      doneReg      <= doneNext;
    end
  end

  assign q    = qReg;
  assign q_n  = qNReg;
  assign busy = (stateReg == SHIFT);
  assign done = doneReg;

endmodule
